// File: rtl/spi_arb_pkg.sv
// Shared types and default parameter values for the SPI bus arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_MASTERS = 2;
  localparam int DEF_NUM_CS      = 8;
  localparam int DEF_RR_MODE     = 0;
  localparam int DEF_TURNAROUND  = 1;
  localparam int DEF_MAX_HOLD    = 0;
  localparam int DEF_CPOL        = 0;

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Engine-side request/grant signals and the shared SPI bus seen by the arbiter.
interface spi_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_CS      = 8
);
  import spi_arb_pkg::*;

  // Handshake: m_req[i] is a level held for the whole transaction; m_gnt[i]
  // rises one cycle after an eligible request is seen in IDLE and falls one
  // edge after the owner drops m_req (or on a forced release).
  logic [NUM_MASTERS-1:0]        m_req;
  logic [NUM_MASTERS-1:0]        m_sclk;
  logic [NUM_MASTERS-1:0]        m_mosi;
  logic [NUM_MASTERS*NUM_CS-1:0] m_cs_n;
  logic [NUM_MASTERS-1:0]        m_gnt;
  logic                          bus_sclk;
  logic                          bus_mosi;
  logic [NUM_CS-1:0]             bus_cs_n;
  logic                          busy;
  logic                          timeout;
  arb_state_e                    dbg_state;

  modport slave (
    input  m_req, m_sclk, m_mosi, m_cs_n,
    output m_gnt, bus_sclk, bus_mosi, bus_cs_n, busy, timeout, dbg_state
  );

  modport master (
    output m_req, m_sclk, m_mosi, m_cs_n,
    input  m_gnt, bus_sclk, bus_mosi, bus_cs_n, busy, timeout, dbg_state
  );

endinterface

// File: rtl/spi_arb_rr_picker.sv
// Combinational winner select: first eligible master searching upward from
// the start index (0 in fixed-priority mode), wrapping modulo NUM_MASTERS.
module spi_arb_rr_picker #(
  parameter int NUM_MASTERS = 2,
  parameter int RR_MODE     = 0,
  localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] eligible,
  input  logic [IDX_W-1:0]       start,
  output logic                   valid,
  output logic [IDX_W-1:0]       winner
);

  always_comb begin : pick
    int idx;
    logic [IDX_W-1:0] cand;
    valid  = |eligible;
    winner = '0;
    idx    = 0;
    cand   = '0;
    // Descending scan so the smallest offset from start overrides the rest.
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = ((RR_MODE != 0) ? int'(start) : 0) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      cand = IDX_W'(idx);
      if (eligible[cand]) winner = cand;
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Grants one of several SPI engines the shared bus, with turnaround gaps,
// optional round-robin and an optional maximum hold time with lockout.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int NUM_CS      = DEF_NUM_CS,
  parameter int RR_MODE     = DEF_RR_MODE,
  parameter int TURNAROUND  = DEF_TURNAROUND,
  parameter int MAX_HOLD    = DEF_MAX_HOLD,
  parameter int CPOL        = DEF_CPOL
) (
  input logic               clk,
  input logic               reset,
  spi_bus_arbiter_if.slave  bus
);

  localparam int IDX_W  = $clog2(NUM_MASTERS);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_e             state, state_nxt;
  logic [IDX_W-1:0]       owner, owner_nxt, rr_ptr, rr_ptr_nxt, winner;
  logic [NUM_MASTERS-1:0] gnt, gnt_nxt, lockout, lockout_nxt, eligible;
  logic [HOLD_W-1:0]      hold_cnt, hold_nxt;
  logic [3:0]             ta_cnt, ta_nxt;
  logic                   timeout_q, timeout_nxt;
  logic                   win_valid, owner_req, hold_expired;

  assign eligible     = bus.m_req & ~lockout;
  assign owner_req    = bus.m_req[owner];
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  spi_arb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .RR_MODE     (RR_MODE)
  ) u_picker (
    .eligible (eligible),
    .start    (rr_ptr),
    .valid    (win_valid),
    .winner   (winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      gnt       <= '0;
      lockout   <= '0;
      hold_cnt  <= '0;
      ta_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      gnt       <= gnt_nxt;
      lockout   <= lockout_nxt;
      hold_cnt  <= hold_nxt;
      ta_cnt    <= ta_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    rr_ptr_nxt  = rr_ptr;
    gnt_nxt     = gnt;
    hold_nxt    = hold_cnt;
    ta_nxt      = ta_cnt;
    timeout_nxt = 1'b0;
    // A locked-out master becomes eligible again once it lets go of m_req.
    lockout_nxt = lockout & bus.m_req;
    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          state_nxt       = ST_GRANT;
          owner_nxt       = winner;
          gnt_nxt         = '0;
          gnt_nxt[winner] = 1'b1;
          hold_nxt        = '0;
          rr_ptr_nxt      = (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          state_nxt = ST_RELEASE;
          gnt_nxt   = '0;
          ta_nxt    = '0;
        end else if (hold_expired) begin
          state_nxt          = ST_RELEASE;
          gnt_nxt            = '0;
          ta_nxt             = '0;
          lockout_nxt[owner] = 1'b1;
          timeout_nxt        = 1'b1;
        end else if (MAX_HOLD != 0) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (ta_cnt == 4'(TURNAROUND - 1)) state_nxt = ST_IDLE;
        else                              ta_nxt    = ta_cnt + 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus mux keys off the registered state, so reset parks the bus immediately.
  always_comb begin
    bus.bus_cs_n = '1;
    bus.bus_sclk = 1'(CPOL);
    bus.bus_mosi = 1'b0;
    if (state == ST_GRANT) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (owner == IDX_W'(i)) begin
          bus.bus_cs_n = bus.m_cs_n[i*NUM_CS +: NUM_CS];
          bus.bus_sclk = bus.m_sclk[i];
          bus.bus_mosi = bus.m_mosi[i];
        end
      end
    end
  end

  assign bus.m_gnt     = gnt;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.timeout   = timeout_q;
  assign bus.dbg_state = state;

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of SPI engines sharing the bus (range 2..8).
REQ-002 SHALL have parameter NUM_CS, default 8, number of active-low chip selects per engine.
REQ-003 SHALL have parameter RR_MODE, default 0: 0 = fixed priority, lowest index wins; 1 = round-robin.
REQ-004 SHALL have parameter TURNAROUND, default 1, bus-idle cycles inserted after each release (range 1..15).
REQ-005 SHALL have parameter MAX_HOLD, default 0, maximum grant length in cycles; 0 means unlimited.
REQ-006 SHALL have parameter CPOL, default 0, idle level driven on bus SCLK when no master owns the bus.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-009 SHALL have port m_req, input, NUM_MASTERS bits, per-master level request, held for the whole transaction.
REQ-010 SHALL have port m_sclk, input, NUM_MASTERS bits, per-master SCLK.
REQ-011 SHALL have port m_mosi, input, NUM_MASTERS bits, per-master MOSI.
REQ-012 SHALL have port m_cs_n, input, NUM_MASTERS*NUM_CS bits, per-master chip selects; master i occupies slice [i*NUM_CS +: NUM_CS].
REQ-013 SHALL have port m_gnt, output, NUM_MASTERS bits, one-hot or zero registered grant.
REQ-014 SHALL have port bus_sclk, output, 1 bit, shared SCLK.
REQ-015 SHALL have port bus_mosi, output, 1 bit, shared MOSI.
REQ-016 SHALL have port bus_cs_n, output, NUM_CS bits, shared chip selects.
REQ-017 SHALL have port busy, output, 1 bit, high in GRANT or RELEASE.
REQ-018 SHALL have port timeout, output, 1 bit, single-cycle pulse on a forced release.

Function
REQ-019 SHALL implement the FSM states IDLE, GRANT and RELEASE.
REQ-020 In IDLE, if any eligible request is present at an edge, the FSM SHALL move to GRANT at that edge, with owner = winner and m_gnt[winner]=1; request-to-grant latency is 1 cycle.
REQ-021 A master is eligible when m_req[i]=1 and lockout[i]=0.
REQ-022 In fixed-priority mode the eligible master with the lowest index SHALL win.
REQ-023 In round-robin mode the search SHALL start at rr_ptr and wrap modulo NUM_MASTERS; rr_ptr SHALL load owner+1 (wrapping) on each grant.
REQ-024 In GRANT, bus_sclk, bus_mosi and bus_cs_n SHALL be combinational copies of the owner's signals, selected by the registered owner index; there is no added latency.
REQ-025 In GRANT, m_req[owner]=0 at an edge SHALL move the FSM to RELEASE and clear m_gnt.
REQ-026 With MAX_HOLD>0, the hold counter SHALL start at 0 on grant and increment each GRANT cycle.
REQ-027 With MAX_HOLD>0, if the hold counter equals MAX_HOLD-1 while m_req[owner]=1, the next edge SHALL force RELEASE, set lockout[owner] and assert timeout for exactly 1 cycle.
REQ-028 lockout[i] SHALL clear on the first edge at which m_req[i]=0.
REQ-029 RELEASE SHALL last exactly TURNAROUND cycles and then return to IDLE.
REQ-030 Outside GRANT, the arbiter SHALL drive bus_cs_n to all ones, bus_sclk to CPOL and bus_mosi to 0.
REQ-031 The gap from one grant dropping to the next grant rising SHALL be TURNAROUND+1 cycles.
REQ-032 Requests from non-owners during GRANT or RELEASE SHALL be ignored until IDLE; the bus SHALL never be preempted except by MAX_HOLD.
REQ-033 A master that drops and re-raises m_req within RELEASE SHALL be treated as a new request in IDLE.
REQ-034 Owner index width SHALL be $clog2(NUM_MASTERS); the hold counter SHALL be wide enough for MAX_HOLD with no wrap.

Reset
REQ-035 On reset the FSM SHALL go to IDLE, with m_gnt=0, busy=0, timeout=0, rr_ptr=0, lockout=0 and counters=0.
REQ-036 Because of REQ-030, bus_cs_n SHALL be all ones and bus_sclk SHALL equal CPOL asynchronously during reset, including reset mid-transaction.

Structure
REQ-037 Package spi_arb_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-038 The winner selection (fixed or rotating priority over the eligible mask) SHALL be one combinational sub-module, spi_arb_rr_picker.

Verification
REQ-039 Fixed priority, N=2: m_req=2'b11 at cycle 0 -> m_gnt=2'b01 at cycle 1; bus_cs_n follows master 0.
REQ-040 RR_MODE=1, N=3: all requests held, each grant held 4 cycles -> grant order 0,1,2,0,1.
REQ-041 TURNAROUND=2: owner drops m_req at cycle 10 -> m_gnt=0 and bus_cs_n=8'hFF in cycles 11-13, and the next grant appears at cycle 14.
REQ-042 MAX_HOLD=16: master 0 holds m_req -> forced release 16 cycles after grant, a one-cycle timeout pulse, and master 1 granted next; master 0 stays ineligible until its m_req falls.
REQ-043 Reset asserted mid-GRANT -> same-cycle m_gnt=0 and bus_cs_n all ones, with bus_sclk=CPOL, and the FSM in IDLE after release.
